// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Definitions shared by the UART receiver and transmitter:
//             the receiver state encoding, the frame data width, the default
//             bit period and a parity helper.
//  Contents : DATA_BITS            - data bits per frame
//             CLKS_PER_BIT_DEFAULT - clk cycles per bit (40 MHz / 115200)
//             uart_state_e         - receiver FSM states
//             parity_ok()          - parity bit check (even or odd)
//  Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int DATA_BITS            = 8;
  localparam int CLKS_PER_BIT_DEFAULT = 347;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } uart_state_e;

  // The data bits and the parity bit together must hold an odd number of
  // ones when odd=1, or an even number when odd=0.
  function automatic logic parity_ok(input logic [DATA_BITS-1:0] data,
                                     input logic                 par_bit,
                                     input logic                 odd);
    return (((^data) ^ par_bit) == odd);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_frontend_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_frontend_if
//  Purpose  : Receive-byte handshake between the UART receiver and the
//             fabric that consumes received commands.
//  Signals  : rx_data    - received byte, stable while rx_valid=1
//             rx_valid   - byte available, held until consumed
//             rx_ready   - consumer accepts when rx_valid && rx_ready
//             frame_err  - one-cycle pulse, stop bit sampled low
//             overrun    - one-cycle pulse, byte lost to a full register
//             parity_err - one-cycle pulse (only with UART_RX_PARITY_EN)
//  Modports : master - receiver side, slave - consumer side
//  Config   : UART_RX_PARITY_EN adds parity_err
//  Revision : 1.0 - initial release
// ============================================================================
interface uart_rx_frontend_if;

  logic [uart_pkg::DATA_BITS-1:0] rx_data;
  logic                           rx_valid;
  logic                           rx_ready;
  logic                           frame_err;
  logic                           overrun;
`ifdef UART_RX_PARITY_EN
  logic                           parity_err;
`endif

  modport master (
    output rx_data,
    output rx_valid,
    output frame_err,
    output overrun,
`ifdef UART_RX_PARITY_EN
    output parity_err,
`endif
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  overrun,
`ifdef UART_RX_PARITY_EN
    input  parity_err,
`endif
    output rx_ready
  );

endinterface
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_sync
//  Purpose  : Two-flop synchronizer for the asynchronous serial line plus a
//             falling-edge pulse on the synchronized signal.
//  Ports    : clk        - system clock
//             rst        - asynchronous active-low reset (flops reset to 1)
//             i_rxd      - raw serial line, idle high
//             o_rxd_sync - synchronized line (2-cycle latency)
//             o_rxd_fall - one-cycle pulse on a synchronized high->low edge
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_sync (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_rxd,
  output logic      o_rxd_sync,
  output logic      o_rxd_fall
);

  logic       r_meta;
  logic       r_sync;
  logic       r_sync_d;
  logic [1:0] r_fill;
  logic       r_armed;

  // The synchronizer flops come out of reset high, so a line that is
  // already low at release would otherwise look like a fresh falling edge.
  // r_fill tracks when r_sync holds a real line sample; edges are only
  // reported after the line has genuinely been seen high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_meta   <= 1'b1;
      r_sync   <= 1'b1;
      r_sync_d <= 1'b1;
      r_fill   <= 2'b00;
      r_armed  <= 1'b0;
    end else begin
      r_meta   <= i_rxd;
      r_sync   <= r_meta;
      r_sync_d <= r_sync;
      r_fill   <= {r_fill[0], 1'b1};
      if (r_fill[1] && r_sync) begin
        r_armed <= 1'b1;
      end
    end
  end

  assign o_rxd_sync = r_sync;
  assign o_rxd_fall = r_armed & r_sync_d & ~r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx_frontend.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_frontend
//  Purpose  : UART receiver for the USB-RS232 link. Recovers 8N1 frames
//             (8E1/8O1 with parity enabled), holds each byte in a
//             valid/ready register and pulses framing / overrun errors.
//  Params   : CLKS_PER_BIT - clk cycles per bit, 8..4095
//             MSB_FIRST    - 0: first data bit is bit 0, 1: it is bit 7
//             PARITY_ODD   - 0: even, 1: odd (only with UART_RX_PARITY_EN)
//  Ports    : clk           - system clock
//             rst           - asynchronous active-low reset
//             usb_rs232_rxd - serial line, idle high, asynchronous
//             rx_if         - received-byte handshake (master modport)
//  Config   : `define UART_RX_PARITY_EN adds a parity bit between the data
//             and the stop bit, plus the parity_err pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_frontend
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int MSB_FIRST    = 0
`ifdef UART_RX_PARITY_EN
  ,
  parameter int PARITY_ODD   = 0
`endif
) (
  input  wire logic          clk,
  input  wire logic          rst,
  input  wire logic          usb_rs232_rxd,
  uart_rx_frontend_if.master rx_if
);

  localparam int                 c_cnt_w     = $clog2(CLKS_PER_BIT);
  localparam int                 c_idx_w     = $clog2(DATA_BITS);
  localparam logic [c_cnt_w-1:0] c_half_load = c_cnt_w'(CLKS_PER_BIT / 2 - 1);
  localparam logic [c_cnt_w-1:0] c_full_load = c_cnt_w'(CLKS_PER_BIT - 1);
  localparam logic [c_idx_w-1:0] c_last_idx  = c_idx_w'(DATA_BITS - 1);

  generate
    if (CLKS_PER_BIT < 8 || CLKS_PER_BIT > 4095) begin : g_bad_clks_per_bit
      $error("uart_rx_frontend: CLKS_PER_BIT must be within 8..4095");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Line conditioning
  // --------------------------------------------------------------------------
  logic w_rxd_sync;
  logic w_rxd_fall;

  uart_rx_sync u_sync (
    .clk        (clk),
    .rst        (rst),
    .i_rxd      (usb_rs232_rxd),
    .o_rxd_sync (w_rxd_sync),
    .o_rxd_fall (w_rxd_fall)
  );

  // --------------------------------------------------------------------------
  // Receive state and datapath registers
  // --------------------------------------------------------------------------
  uart_state_e              r_state;
  uart_state_e              w_state_next;
  logic [c_cnt_w-1:0]       r_cnt;
  logic [c_idx_w-1:0]       r_bit_idx;
  logic [DATA_BITS-1:0]     r_shift;
  logic [DATA_BITS-1:0]     w_shift_next;
  logic                     w_cnt_zero;

  // Control strobes from the next-state logic
  logic w_load_half;
  logic w_load_full;
  logic w_bit_clr;
  logic w_shift_en;
  logic w_byte_done;
  logic w_frame_bad;

  // Output holding registers
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid;
  logic                 r_frame_err;
  logic                 r_overrun;

`ifdef UART_RX_PARITY_EN
  logic r_par_bit;
  logic r_parity_err;
  logic w_par_sample;
  logic w_par_bad;
`endif

  assign w_cnt_zero = (r_cnt == '0);

  // Bit placement: the shift direction decides whether the first data bit
  // lands in bit 0 or bit 7 once all eight samples are in.
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign w_shift_next = {r_shift[DATA_BITS-2:0], w_rxd_sync};
    end else begin : g_lsb_first
      assign w_shift_next = {w_rxd_sync, r_shift[DATA_BITS-1:1]};
    end
  endgenerate

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state and control strobes
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_load_half  = 1'b0;
    w_load_full  = 1'b0;
    w_bit_clr    = 1'b0;
    w_shift_en   = 1'b0;
    w_byte_done  = 1'b0;
    w_frame_bad  = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_sample = 1'b0;
    w_par_bad    = 1'b0;
`endif

    case (r_state)
      IDLE: begin
        // Half a bit period puts every later sample at mid-bit.
        if (w_rxd_fall) begin
          w_load_half  = 1'b1;
          w_state_next = START;
        end
      end

      START: begin
        if (w_cnt_zero) begin
          if (!w_rxd_sync) begin
            w_load_full  = 1'b1;
            w_bit_clr    = 1'b1;
            w_state_next = DATA;
          end else begin
            // Line already back high at mid start bit: a glitch.
            w_state_next = IDLE;
          end
        end
      end

      DATA: begin
        if (w_cnt_zero) begin
          w_shift_en  = 1'b1;
          w_load_full = 1'b1;
          if (r_bit_idx == c_last_idx) begin
`ifdef UART_RX_PARITY_EN
            w_state_next = PARITY;
`else
            w_state_next = STOP;
`endif
          end
        end
      end

      PARITY: begin
`ifdef UART_RX_PARITY_EN
        if (w_cnt_zero) begin
          w_par_sample = 1'b1;
          w_load_full  = 1'b1;
          w_state_next = STOP;
        end
`else
        w_state_next = IDLE;
`endif
      end

      STOP: begin
        if (w_cnt_zero) begin
          if (!w_rxd_sync) begin
            // Bad stop bit: drop the byte and wait out a held-low line.
            w_frame_bad  = 1'b1;
            w_state_next = BREAK;
          end else begin
            w_state_next = IDLE;
`ifdef UART_RX_PARITY_EN
            if (!parity_ok(r_shift, r_par_bit, 1'(PARITY_ODD))) begin
              w_par_bad = 1'b1;
            end else begin
              w_byte_done = 1'b1;
            end
`else
            w_byte_done = 1'b1;
`endif
          end
        end
      end

      BREAK: begin
        if (w_rxd_sync) begin
          w_state_next = IDLE;
        end
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Bit timer, bit index and shift register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      if (w_load_half) begin
        r_cnt <= c_half_load;
      end else if (w_load_full) begin
        r_cnt <= c_full_load;
      end else if (!w_cnt_zero) begin
        r_cnt <= r_cnt - 1'b1;
      end

      if (w_bit_clr) begin
        r_bit_idx <= '0;
      end else if (w_shift_en) begin
        r_bit_idx <= r_bit_idx + 1'b1;
      end

      if (w_shift_en) begin
        r_shift <= w_shift_next;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_par_bit    <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      if (w_par_sample) begin
        r_par_bit <= w_rxd_sync;
      end
      r_parity_err <= w_par_bad;
    end
  end

  assign rx_if.parity_err = r_parity_err;
`endif

  // --------------------------------------------------------------------------
  // Holding register and error pulses
  // --------------------------------------------------------------------------
  // A completed byte may overwrite the register only if it is empty or being
  // consumed on this same edge; otherwise the new byte is the one dropped.
  // frame_err and byte completion come from exclusive STOP branches, so
  // frame_err and overrun can never coincide.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_frame_bad;
      r_overrun   <= 1'b0;
      if (w_byte_done) begin
        if (!r_rx_valid || rx_if.rx_ready) begin
          r_rx_data  <= r_shift;
          r_rx_valid <= 1'b1;
        end else begin
          r_overrun  <= 1'b1;
        end
      end else if (r_rx_valid && rx_if.rx_ready) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign rx_if.rx_data   = r_rx_data;
  assign rx_if.rx_valid  = r_rx_valid;
  assign rx_if.frame_err = r_frame_err;
  assign rx_if.overrun   = r_overrun;

endmodule
`default_nettype wire
